// File: rtl/ddr3_sample_writer.sv
// ddr3_sample_writer: packs 16-bit audio samples into 256-bit words and
// writes each word to a circular DDR3 region through the MIG 7-series
// application interface. Everything runs on ui_clk.
module ddr3_sample_writer #(
    parameter int ADDR_W           = 29,
    parameter int SAMPLE_W         = 16,
    parameter int WORD_W           = 256,
    parameter int SAMPLES_PER_WORD = 16,
    parameter int BASE_ADDR        = 0,
    parameter int REGION_WORDS     = 1024,
    parameter int ADDR_STEP        = 8
) (
    input  logic                ui_clk,
    input  logic                sys_rst,
    input  logic                init_calib_complete,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                flush,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [WORD_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [WORD_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    output logic                idle,
    output logic                wrap,
    output logic [31:0]         words_written
);

    localparam int CNT_W = $clog2(SAMPLES_PER_WORD + 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(SAMPLES_PER_WORD);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + (REGION_WORDS - 1) * ADDR_STEP);

    typedef enum logic {
        WAIT_CAL = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic                cal_seen;
    logic [CNT_W-1:0]    pack_cnt;
    logic [WORD_W-1:0]   pack_buf;
    logic                pending_flush;
    logic                out_valid;
    logic [WORD_W-1:0]   out_data;
    logic [ADDR_W-1:0]   out_addr;
    logic                cmd_done;
    logic                data_done;
    logic [ADDR_W-1:0]   next_addr;

    logic                accept;
    logic                xfer;
    logic                cmd_ok;
    logic                data_ok;
    logic                wr_done;

    // Once calibration has been observed the block stays in RUN until reset.
    assign cal_seen = (state == RUN);

    // State register for the calibration gate.
    always_ff @(posedge ui_clk) begin
        if (!sys_rst) state <= WAIT_CAL;
        else          state <= state_nxt;
    end

    // Next-state logic: leave WAIT_CAL on the first calibrated cycle, ignore later drops.
    always_comb begin
        state_nxt = state;
        if (state == WAIT_CAL && init_calib_complete) state_nxt = RUN;
    end

    // FSM outputs: sample handshake and emptiness flag (idle reads 1 while
    // waiting for calibration because the datapath holds nothing).
    always_comb begin
        s_ready = 1'b0;
        if (state == RUN) s_ready = (pack_cnt < FULL) && !pending_flush;
        idle = (pack_cnt == '0) && !out_valid && !pending_flush;
    end

    assign accept = s_valid && s_ready;
    // A full or flushed pack moves to the issue register only when that register is free.
    assign xfer   = cal_seen && ((pack_cnt == FULL) || pending_flush) && !out_valid;

    // Completion counts handshakes that land in the current cycle.
    assign cmd_ok  = cmd_done  || (app_en && app_rdy);
    assign data_ok = data_done || (app_wdf_wren && app_wdf_rdy);
    assign wr_done = out_valid && cmd_ok && data_ok;

    // ---- stage 0: sample packing ----
    // Pack accepted samples lane by lane; a flush marks the partial word for transfer.
    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            pack_cnt      <= '0;
            pack_buf      <= '0;
            pending_flush <= 1'b0;
        end else if (xfer) begin
            pack_cnt      <= '0;
            pack_buf      <= '0;
            pending_flush <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
                    if (pack_cnt == CNT_W'(i)) pack_buf[i*SAMPLE_W +: SAMPLE_W] <= s_data;
                end
                pack_cnt <= pack_cnt + CNT_W'(1);
            end
            // A sample taken alongside the flush joins the word before it is emitted.
            if (flush && ((pack_cnt != '0) || accept)) pending_flush <= 1'b1;
        end
    end

    // ---- stage 1: MIG write issue ----
    // Latch the word with its address at transfer, then track the two MIG handshakes.
    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_addr      <= BASE;
            cmd_done      <= 1'b0;
            data_done     <= 1'b0;
            next_addr     <= BASE;
            words_written <= '0;
            wrap          <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= pack_buf;
                out_addr  <= next_addr;
                // Address advances here so out_addr always names the word in flight.
                if (next_addr == LAST_ADDR) begin
                    next_addr <= BASE;
                    wrap      <= 1'b1;
                end else begin
                    next_addr <= next_addr + STEP;
                end
            end else if (out_valid) begin
                if (wr_done) begin
                    out_valid     <= 1'b0;
                    cmd_done      <= 1'b0;
                    data_done     <= 1'b0;
                    words_written <= words_written + 32'd1;
                end else begin
                    if (app_en && app_rdy)             cmd_done  <= 1'b1;
                    if (app_wdf_wren && app_wdf_rdy)   data_done <= 1'b1;
                end
            end
        end
    end

    assign app_en       = out_valid && !cmd_done;
    assign app_wdf_wren = out_valid && !data_done;
    assign app_wdf_end  = app_wdf_wren;
    assign app_addr     = out_addr;
    assign app_wdf_data = out_data;
    assign app_cmd      = 3'b000;
    assign app_wdf_mask = '0;

endmodule
